gray_mem_arbiter: RTL
=====================

# gray_mem_arbiter

Two-client arbiter sharing the single grayscale image memory port (gray_req/gray_addr/gray_ready/gray_data) between the LBP engine (client 0) and a second image engine (client 1). Per-read arbitration uses round-robin priority. A lock lets one client own the port for a neighbourhood burst, and a burst-length watchdog bounds starvation. The block sits between both engines and the testbench-side gray memory.

## Interface
- AW, 14, address width (128x128 image)
- DW, 8, pixel width
- MAX_LOCK, 9, maximum consecutive grants to a locked owner before forced release (one 3x3 window)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- gray_ready  in  1  memory ready; no read is issued while low
- gray_data  in  DW  read data, valid in the cycle gray_req is high
- gray_req  out  reg 1  memory read strobe
- gray_addr  out  reg AW  memory read address
- c0_req, c1_req  in  1  client read request
- c0_addr, c1_addr  in  AW  client read address
- c0_lock, c1_lock  in  1  client keeps ownership after this grant
- c0_gnt, c1_gnt  out  1  combinational; address accepted this cycle
- c0_rvalid, c1_rvalid  out  reg 1  read data valid for the client
- c0_rdata, c1_rdata  out  DW  equals gray_data; qualify with rvalid

## Operation
- State machine has three states: FREE, OWN0, OWN1. Reset state is FREE. Priority pointer ptr resets to 0. Lock counter lcnt (4 bits) resets to 0.
- Eligibility: a grant is possible only when gray_ready=1.
- Winner selection:
  - FREE, one requester: that client wins.
  - FREE, both requesting: client ptr wins.
  - OWNk: only client k can win; the other client's request is held off (gnt=0).
- On a grant to client k at cycle T:
  - ck_gnt=1 during T. The client must hold req/addr stable until gnt.
  - At the edge ending T: gray_req<=1, gray_addr<=ck_addr, owner tag<=k.
  - ptr<=~k, but only when the next state is FREE.
- Lock transitions:
  - Grant with ck_lock=1 and lcnt+1<MAX_LOCK: next state OWNk, lcnt<=lcnt+1.
  - Grant with ck_lock=0: next state FREE, lcnt<=0.
  - Grant with ck_lock=1 and lcnt+1==MAX_LOCK: forced release to FREE, lcnt<=0, ptr<=~k.
- Owner dropping req: in OWNk, if ck_req=0 and ck_lock=0, go to FREE without a grant. If ck_lock=1 and ck_req=0, ownership is retained and lcnt is unchanged.
- Idle cycle: with no grant, gray_req<=0 and gray_addr holds its value.
- Data return: cycle T+1 has ck_rvalid=1 for the tagged owner only; the other client's rvalid is 0.
- Clients sample ck_rdata at the edge ending T+1.

## Timing
- Reset values: gray_req=0, gray_addr=0, c0/c1_rvalid=0, state FREE, ptr=0, lcnt=0. c0/c1_gnt are 0 while reset is asserted.
- Address latency is 1 cycle from gnt to gray_req/gray_addr.
- Read latency is 1 cycle from gnt to rvalid. rdata is valid in the same cycle as rvalid.
- Throughput is one read per cycle. Back-to-back grants are allowed, including alternating clients.
- gray_ready low during cycle T: no gnt in T; gray_req=0 at T+1; state and lcnt are unchanged.
- Simultaneous requests in FREE with ptr=0: c0 is granted; ptr=1 afterwards if c0 did not lock.
- Reset mid-operation: any in-flight rvalid is dropped. No rvalid is asserted after reset deasserts until a new grant.
- Addresses pass through unmodified. The arbiter does no boundary checking.

## Test plan
- Single client: c0_req with addr 129, gray_ready=1 → c0_gnt in cycle T; gray_req=1 and gray_addr=129 at T+1; c0_rvalid=1 with rdata=mem[129] at T+1; c1_rvalid stays 0.
- Contention without lock: both clients request continuously, addr0=5 and addr1=700 → grants alternate c0,c1,c0,c1; gray_addr sequence 5,700,5,700.
- Locked burst: c0 requests 9 addresses with lock=1 while c1 requests continuously → c1_gnt=0 for 9 cycles; forced release after the 9th c0 grant; c1 is granted next.
- Early unlock: c0 locks for 3 grants, then lock=0 on the 4th → c1 is granted in the cycle after the 4th c0 grant.
- gray_ready=0 for 4 cycles with both requesting → no gnt and gray_req=0 during the stall; arbitration resumes with ptr unchanged.
- Reset asserted the cycle after a grant → rvalid=0 and gray_req=0 immediately; after release, state is FREE and c0 wins the first simultaneous request.

Source files
------------

// File: rtl/gray_mem_arbiter.sv
// Two-client round-robin arbiter for the shared grayscale memory read port.
// A client may lock the port for a burst; MAX_LOCK bounds how long the other client waits.
module gray_mem_arbiter #(
  parameter int AW       = 14,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_ready,
  input  logic [DW-1:0] gray_data,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic          c0_req,
  input  logic          c1_req,
  input  logic [AW-1:0] c0_addr,
  input  logic [AW-1:0] c1_addr,
  input  logic          c0_lock,
  input  logic          c1_lock,
  output logic          c0_gnt,
  output logic          c1_gnt,
  output logic          c0_rvalid,
  output logic          c1_rvalid,
  output logic [DW-1:0] c0_rdata,
  output logic [DW-1:0] c1_rdata
);

  typedef enum logic [1:0] {FREE, OWN0, OWN1} state_t;

  localparam logic [4:0] MAX_L = 5'(MAX_LOCK);

  state_t      state_q;
  logic        ptr_q;
  logic [3:0]  lcnt_q;
  logic [4:0]  lcnt_inc;
  logic        gnt_any;
  logic        gnt_lock;

  assign lcnt_inc = {1'b0, lcnt_q} + 5'd1;
  assign gnt_any  = c0_gnt | c1_gnt;
  assign gnt_lock = c1_gnt ? c1_lock : c0_lock;
  assign c0_rdata = gray_data;
  assign c1_rdata = gray_data;

  // An owner shuts the other client out entirely; in FREE the pointer breaks ties.
  always_comb begin
    c0_gnt = 1'b0;
    c1_gnt = 1'b0;
    if (!reset && gray_ready) begin
      unique case (state_q)
        FREE: begin
          if (c0_req && (!c1_req || !ptr_q)) c0_gnt = 1'b1;
          else if (c1_req)                   c1_gnt = 1'b1;
        end
        OWN0:    c0_gnt = c0_req;
        OWN1:    c1_gnt = c1_req;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FREE;
      ptr_q     <= 1'b0;
      lcnt_q    <= 4'd0;
      gray_req  <= 1'b0;
      gray_addr <= '0;
      c0_rvalid <= 1'b0;
      c1_rvalid <= 1'b0;
    end else begin
      gray_req  <= gnt_any;
      c0_rvalid <= c0_gnt;
      c1_rvalid <= c1_gnt;
      if (gnt_any) begin
        gray_addr <= c1_gnt ? c1_addr : c0_addr;
        if (gnt_lock && (lcnt_inc < MAX_L)) begin
          state_q <= c1_gnt ? OWN1 : OWN0;
          lcnt_q  <= lcnt_inc[3:0];
        end else begin
          // Unlocked grant or watchdog expiry: hand priority to the other client.
          state_q <= FREE;
          lcnt_q  <= 4'd0;
          ptr_q   <= ~c1_gnt;
        end
      end else if (gray_ready) begin
        if ((state_q == OWN0 && !c0_req && !c0_lock) ||
            (state_q == OWN1 && !c1_req && !c1_lock)) begin
          state_q <= FREE;
          lcnt_q  <= 4'd0;
        end
      end
    end
  end

endmodule
